// File: rtl/sparc_ifu_ibuf_pkg.sv
// Shared constants and types for the per-thread instruction buffer.
// Optional IBUF_PARITY_EN build uses even_par() for per-entry parity.
package sparc_ifu_ibuf_pkg;

  localparam int unsigned NTHR_DEF  = 4;
  localparam int unsigned DEPTH_DEF = 2;
  localparam logic [31:0] NOP_INST  = 32'h0100_0000;

  typedef logic [$clog2(NTHR_DEF)-1:0] tid_t;
  typedef logic [$clog2(DEPTH_DEF):0]  ptr_t;

  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sparc_ifu_ibuf_if.sv
// Fetch/decode <-> instruction buffer signal bundle.
// master = fetch/decode control side, slave = the buffer itself.
interface sparc_ifu_ibuf_if
  import sparc_ifu_ibuf_pkg::*;
#(
  parameter int unsigned NTHR = NTHR_DEF
);
  localparam int unsigned TIDW = $clog2(NTHR);

  logic [31:0]     fdp_ibuf_inst_f;
  logic [NTHR-1:0] fdp_ibuf_wr_f;
  logic [NTHR-1:0] ibuf_fdp_rdy_f;
  logic [NTHR-1:0] fcl_ibuf_flush;
  logic            dcl_ibuf_stall_s;
  logic [31:0]     ibuf_dtu_inst_s;
  logic            ibuf_dtu_vld_s;
  logic [TIDW-1:0] ibuf_dtu_tid_s;
  logic [NTHR-1:0] ibuf_fcl_empty;
  logic            ibuf_dtu_perr_s;

  modport master (
    output fdp_ibuf_inst_f, fdp_ibuf_wr_f, fcl_ibuf_flush, dcl_ibuf_stall_s,
    input  ibuf_fdp_rdy_f, ibuf_dtu_inst_s, ibuf_dtu_vld_s, ibuf_dtu_tid_s,
           ibuf_fcl_empty, ibuf_dtu_perr_s
  );

  modport slave (
    input  fdp_ibuf_inst_f, fdp_ibuf_wr_f, fcl_ibuf_flush, dcl_ibuf_stall_s,
    output ibuf_fdp_rdy_f, ibuf_dtu_inst_s, ibuf_dtu_vld_s, ibuf_dtu_tid_s,
           ibuf_fcl_empty, ibuf_dtu_perr_s
  );

endinterface

// File: rtl/sparc_ifu_ibuf_fifo.sv
// One thread's circular instruction FIFO with wrap-bit pointers.
// IBUF_PARITY_EN adds a stored even-parity bit per entry.
module sparc_ifu_ibuf_fifo
  import sparc_ifu_ibuf_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr,
  input  logic [31:0] i_data,
  input  logic        i_flush,
  input  logic        i_pop,
  output logic [31:0] o_head,
  output logic        o_perr,
  output logic        o_full,
  output logic        o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_DEPTH = DEPTH[AW:0];

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [31:0] r_mem [DEPTH];
  logic [AW:0] w_count;
  logic        w_push;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (w_count == PTR_DEPTH);
  assign o_empty = (w_count == '0);
  // Full is judged on registered state only; a flush in the same cycle discards the write.
  assign w_push  = i_wr & ~o_full & ~i_flush;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_flush)
        r_rd_ptr <= r_wr_ptr;
      else if (i_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

`ifdef IBUF_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push)
      r_par[r_wr_ptr[AW-1:0]] <= even_par(i_data);
  end

  assign o_perr = even_par(o_head) ^ r_par[r_rd_ptr[AW-1:0]];
`else
  assign o_perr = 1'b0;
`endif

  a_wr_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_wr && o_full && !i_flush))
    else $warning("ibuf: write dropped, thread buffer full");

endmodule

// File: rtl/sparc_ifu_ibuf.sv
// Per-thread instruction buffer: NTHR FIFOs, round-robin select of the S-stage instruction.
// Build macro IBUF_PARITY_EN enables per-entry parity and ibuf_dtu_perr_s.
module sparc_ifu_ibuf
  import sparc_ifu_ibuf_pkg::*;
#(
  parameter int unsigned NTHR     = NTHR_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic [31:0] NOP_INST = sparc_ifu_ibuf_pkg::NOP_INST
)
(
  input logic              rclk,
  input logic              arst_l,
  sparc_ifu_ibuf_if.slave  bus
);
  localparam int unsigned     TIDW    = $clog2(NTHR);
  localparam logic [NTHR-1:0] THR_ONE = {{(NTHR-1){1'b0}}, 1'b1};

  logic [31:0]     w_head [NTHR];
  logic [NTHR-1:0] w_full;
  logic [NTHR-1:0] w_empty;
  logic [NTHR-1:0] w_perr;
  logic [NTHR-1:0] w_cand;
  logic [NTHR-1:0] w_pop;
  logic            w_vld;
  logic            w_issue;
  logic [TIDW-1:0] w_win;
  logic [TIDW-1:0] w_idx;
  logic [TIDW-1:0] r_rr;

  for (genvar g = 0; g < NTHR; g++) begin : g_thr
    sparc_ifu_ibuf_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (rclk),
      .rst_n   (arst_l),
      .i_wr    (bus.fdp_ibuf_wr_f[g]),
      .i_data  (bus.fdp_ibuf_inst_f),
      .i_flush (bus.fcl_ibuf_flush[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_perr  (w_perr[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign w_cand = ~w_empty & ~bus.fcl_ibuf_flush;

  // Scan starts one past the last issuer; NTHR is a power of 2 so TIDW-bit add wraps.
  always_comb begin
    w_vld = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = 1; k <= NTHR; k++) begin
      w_idx = r_rr + TIDW'(k);
      if (!w_vld && w_cand[w_idx]) begin
        w_vld = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_issue = w_vld & ~bus.dcl_ibuf_stall_s;
  assign w_pop   = w_issue ? (THR_ONE << w_win) : '0;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)
      r_rr <= '0;
    else if (w_issue)
      r_rr <= w_win;
  end

  assign bus.ibuf_fdp_rdy_f   = ~w_full;
  assign bus.ibuf_fcl_empty   = w_empty;
  assign bus.ibuf_dtu_vld_s   = w_vld;
  assign bus.ibuf_dtu_tid_s   = w_win;
  assign bus.ibuf_dtu_inst_s  = w_vld ? w_head[w_win] : NOP_INST;
  assign bus.ibuf_dtu_perr_s  = w_vld & w_perr[w_win];

endmodule

// File: tb/tb_sparc_ifu_ibuf.sv
// Scoreboard bench for sparc_ifu_ibuf: queue-per-thread reference model, directed then random traffic.
module tb_sparc_ifu_ibuf;
  import sparc_ifu_ibuf_pkg::*;

  localparam int unsigned NTHR  = 4;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic        vld;
    tid_t        tid;
    logic [31:0] inst;
    logic [3:0]  rdy;
    logic [3:0]  empty;
  } cyc_t;

  typedef struct packed {
    tid_t        tid;
    logic [31:0] inst;
  } iss_t;

  logic rclk = 1'b0;
  logic arst_l;

  sparc_ifu_ibuf_if #(.NTHR(NTHR)) bus ();

  sparc_ifu_ibuf #(
    .NTHR  (NTHR),
    .DEPTH (DEPTH)
  ) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  cyc_t        exp_q [$];
  iss_t        iss_q [$];
  logic [31:0] mq [NTHR][$];
  int unsigned rr;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus and records what the reference predicts for it.
  task automatic drive(input logic [3:0] wr, input logic [31:0] d,
                       input logic [3:0] fl, input logic st);
    cyc_t        e;
    iss_t        is;
    int unsigned sz [NTHR];
    int unsigned win;
    int unsigned t;
    bit          v;
    logic [31:0] dummy;
    bus.fdp_ibuf_wr_f    = wr;
    bus.fdp_ibuf_inst_f  = d;
    bus.fcl_ibuf_flush   = fl;
    bus.dcl_ibuf_stall_s = st;
    for (int unsigned i = 0; i < NTHR; i++) sz[i] = mq[i].size();
    v   = 1'b0;
    win = 0;
    for (int unsigned k = 1; k <= NTHR; k++) begin
      t = (rr + k) % NTHR;
      if (!v && sz[t] != 0 && !fl[t]) begin
        v   = 1'b1;
        win = t;
      end
    end
    e.vld  = v;
    e.tid  = tid_t'(win);
    e.inst = v ? mq[win][0] : NOP_INST;
    for (int unsigned i = 0; i < NTHR; i++) begin
      e.rdy[i]   = (sz[i] < DEPTH);
      e.empty[i] = (sz[i] == 0);
    end
    exp_q.push_back(e);
    if (v && !st) begin
      is.tid  = tid_t'(win);
      is.inst = mq[win][0];
      iss_q.push_back(is);
      dummy = mq[win].pop_front();
      rr = win;
    end
    for (int unsigned i = 0; i < NTHR; i++) begin
      if (fl[i])
        mq[i].delete();
      else if (wr[i] && sz[i] < DEPTH)
        mq[i].push_back(d);
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(4'b0000, 32'h0, 4'b0000, 1'b0);
  endtask

  always @(negedge rclk) begin
    cyc_t e;
    iss_t is;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underrun", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("vld",   {63'd0, bus.ibuf_dtu_vld_s}, {63'd0, e.vld});
        chk("tid",   {62'd0, bus.ibuf_dtu_tid_s}, {62'd0, e.tid});
        chk("inst",  {32'd0, bus.ibuf_dtu_inst_s}, {32'd0, e.inst});
        chk("rdy",   {60'd0, bus.ibuf_fdp_rdy_f}, {60'd0, e.rdy});
        chk("empty", {60'd0, bus.ibuf_fcl_empty}, {60'd0, e.empty});
        chk("perr",  {63'd0, bus.ibuf_dtu_perr_s}, 64'd0);
      end
      if (bus.ibuf_dtu_vld_s && !bus.dcl_ibuf_stall_s) begin
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", {32'd0, bus.ibuf_dtu_inst_s}, 64'd0);
        end else begin
          is = iss_q.pop_front();
          chk("issue_tid",  {62'd0, bus.ibuf_dtu_tid_s}, {62'd0, is.tid});
          chk("issue_inst", {32'd0, bus.ibuf_dtu_inst_s}, {32'd0, is.inst});
        end
      end
    end
  end

  initial begin
    logic [3:0] wr;
    logic [3:0] fl;
    int unsigned t;
    arst_l = 1'b0;
    rr = 0;
    bus.fdp_ibuf_wr_f    = '0;
    bus.fdp_ibuf_inst_f  = '0;
    bus.fcl_ibuf_flush   = '0;
    bus.dcl_ibuf_stall_s = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_vld",   {63'd0, bus.ibuf_dtu_vld_s}, 64'd0);
    chk("rst_tid",   {62'd0, bus.ibuf_dtu_tid_s}, 64'd0);
    chk("rst_inst",  {32'd0, bus.ibuf_dtu_inst_s}, {32'd0, 32'h0100_0000});
    chk("rst_rdy",   {60'd0, bus.ibuf_fdp_rdy_f}, 64'hF);
    chk("rst_empty", {60'd0, bus.ibuf_fcl_empty}, 64'hF);
    chk("rst_perr",  {63'd0, bus.ibuf_dtu_perr_s}, 64'd0);
    arst_l = 1'b1;
    mon_en = 1'b1;

    idle(3);
    // Single write to T2, visible the next cycle then drained.
    drive(4'b0100, 32'h8200_2001, 4'b0000, 1'b0);
    idle(3);
    // Fill T0 under stall, third write dropped, hold A for several stalled cycles.
    drive(4'b0001, 32'hA000_000A, 4'b0000, 1'b1);
    drive(4'b0001, 32'hB000_000B, 4'b0000, 1'b1);
    drive(4'b0001, 32'hC000_000C, 4'b0000, 1'b1);
    repeat (3) drive(4'b0000, 32'h0, 4'b0000, 1'b1);
    idle(4);
    // T0/T1 two entries each with rr at T0: expect T1,T0,T1,T0.
    drive(4'b0001, 32'h1000_0000, 4'b0000, 1'b1);
    drive(4'b0010, 32'h1100_0000, 4'b0000, 1'b1);
    drive(4'b0001, 32'h1000_0001, 4'b0000, 1'b1);
    drive(4'b0010, 32'h1100_0001, 4'b0000, 1'b1);
    idle(6);
    // T3 flushed in the same cycle as a new write to it.
    drive(4'b1000, 32'h3300_0001, 4'b0000, 1'b1);
    drive(4'b1000, 32'h3300_0002, 4'b1000, 1'b0);
    idle(3);

    for (int i = 0; i < 800; i++) begin
      wr = '0;
      fl = '0;
      t  = $urandom_range(NTHR - 1);
      if ($urandom_range(3) != 0 && mq[t].size() < DEPTH) wr[t] = 1'b1;
      for (int unsigned j = 0; j < NTHR; j++)
        if ($urandom_range(23) == 0) fl[j] = 1'b1;
      drive(wr, $urandom, fl, ($urandom_range(2) == 0));
    end
    idle(8);
    mon_en = 1'b0;
    chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sparc_ifu_ibuf.md
Name: sparc_ifu_ibuf

Overview:
- Per-thread instruction buffer between the fetch datapath (F stage) and the S/D stage instruction register.
- Absorbs fetched instructions while decode stalls or another thread holds the pipe.
- Round-robin selects one valid thread per cycle and presents its oldest instruction as the S-stage instruction (fdp_dtu_inst_s equivalent) to the immediate/decode datapath.

Parameters:
- NTHR, 4, number of hardware threads (power of 2, 2..4).
- DEPTH, 2, entries per thread FIFO (power of 2, 2..4).
- NOP_INST, 32'h0100_0000, value driven on inst_s when no valid instruction.

Ports:
- rclk  in  1  core clock.
- arst_l  in  1  reset; asynchronous assertion, active-low.
- fdp_ibuf_inst_f  in  32  fetched instruction.
- fdp_ibuf_wr_f  in  NTHR  one-hot write strobe, thread of fdp_ibuf_inst_f.
- ibuf_fdp_rdy_f  out  NTHR  per-thread not-full.
- fcl_ibuf_flush  in  NTHR  per-thread flush (trap/redirect).
- dcl_ibuf_stall_s  in  1  decode cannot accept this cycle.
- ibuf_dtu_inst_s  out  32  selected S-stage instruction.
- ibuf_dtu_vld_s  out  1  inst_s valid.
- ibuf_dtu_tid_s  out  log2(NTHR)  thread id of inst_s.
- ibuf_fcl_empty  out  NTHR  per-thread empty.
- ibuf_dtu_perr_s  out  1  parity error on inst_s (see Optional Feature).

Behaviour:
- Reset (arst_l low, async):
  - All FIFOs empty, pointers 0, round-robin pointer = thread 0.
  - Outputs: rdy all 1, empty all 1, vld 0, tid 0, inst_s = NOP_INST, perr 0.
- Per-thread FIFO:
  - Circular; rd/wr pointers log2(DEPTH) bits plus wrap bit.
  - count = wr - rd; full when count == DEPTH.
- Write:
  - Happens when fdp_ibuf_wr_f[t] & rdy[t].
  - rdy[t] = ~full[t], from registered state only; no same-cycle pop bypass.
  - Write while ~rdy: dropped; assertion flags it.
  - Written entry becomes visible next cycle (no write-through to inst_s).
- Select:
  - Candidates = threads with ~empty & ~flush.
  - Priority starts at (rr_ptr+1) mod NTHR, wrapping.
  - vld = any candidate. tid/inst_s are the winner's head entry, combinational from state.
  - inst_s = NOP_INST when ~vld.
- Pop:
  - Happens when vld & ~dcl_ibuf_stall_s: winner's rd pointer increments and rr_ptr <= winner.
  - On stall: nothing changes and the same thread/inst is re-presented.
- Flush:
  - fcl_ibuf_flush[t] clears thread t (rd <= wr) at the clock edge.
  - Same-cycle write to t is discarded.
  - t is excluded from selection that cycle, so no pop of a flushed entry.
  - Other threads are unaffected.
- Simultaneous write and pop to the same non-full thread: both occur, count unchanged.
- Latency: write at edge N, earliest vld at N+1 (1 cycle F->S).

Optional Feature:
- IBUF_PARITY_EN defined:
  - Each entry stores an even-parity bit computed from fdp_ibuf_inst_f on write.
  - On read, ibuf_dtu_perr_s = vld & (^inst ^ stored_par).
  - Instruction still issues; fcl handles the error.
- Undefined: no parity storage; ibuf_dtu_perr_s tied 0.

Decomposition:
- Package sparc_ifu_ibuf_pkg: NTHR/DEPTH defaults, NOP_INST constant, tid_t typedef (log2 NTHR), ptr_t typedef.
- Sub-module sparc_ifu_ibuf_fifo: one thread FIFO, instantiated NTHR times. Contains storage, pointers, full/empty and optional parity.
- Top holds the round-robin arbiter and output mux.

Test Plan:
- Reset then idle -> vld=0, inst_s=32'h0100_0000, rdy=4'b1111, empty=4'b1111.
- Write 0x8200_2001 to T2, no stall:
  - cycle+1: vld=1, tid=2, inst_s=0x8200_2001.
  - cycle+2: vld=0, empty[2]=1.
- Fill T0 with A,B (DEPTH=2):
  - rdy[0]=0.
  - Third write C is dropped.
  - Stall 3 cycles: inst_s holds A.
  - Release stall: A then B issue.
- T0 and T1 each hold 2 entries, rr_ptr=0, no stall -> issue order T1,T0,T1,T0.
- T3 holds 1 entry; flush[3] in the same cycle as a write to T3 -> vld=0 that cycle, T3 empty next cycle, written inst lost.
- IBUF_PARITY_EN: force stored parity bit flip on a T1 entry -> on issue vld=1, perr=1; with macro undefined perr stays 0.
